cfu_mat_sequencer: RTL

Next-generation matrix-multiply sequencer for the CFU.
- Replaces the fixed N×N schedule with instruction-driven MAC bursts of programmable inner dimension K (1..64), with independent A and B base addresses.
- Adds an accumulate mode, a runtime lane mask, a result-writeback handshake and program-overrun error detection.
- Sits between the GPIO start/done switches, the instruction memory, the AB register file and the N PE lanes.

---
 rtl/cfu_mat_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/cfu_mat_sequencer.sv
// cfu_mat_sequencer: instruction-driven MAC burst sequencer feeding N PE lanes from the AB register file
module cfu_mat_sequencer #(
  parameter int N          = 16,
  parameter int REGN       = 512,
  parameter int B_START    = 256,
  parameter int IMEM_DEPTH = 256,
  parameter int PCW        = $clog2(IMEM_DEPTH),
  parameter int AW         = $clog2(REGN)
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           ONSWT,
  output logic           OFFSWT,
  input  logic [N-1:0]   LANE_MASK,
  output logic [PCW-1:0] PC_INS,
  input  logic [31:0]    INSTRDATA,
  output logic           RD_EN,
  output logic [AW-1:0]  RD_ADDR_A,
  output logic [AW-1:0]  RD_ADDR_B,
  output logic [N-1:0]   RST_MUL,
  output logic [N-1:0]   MAC_CTRL,
  output logic           WR_VALID,
  input  logic           WR_READY,
  output logic [3:0]     WR_SLOT,
  output logic           BUSY,
  output logic           ERR
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_CLEAR, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;
  logic [PCW-1:0] r_pc;
  logic [N-1:0] r_mask, r_mac;
  logic [5:0] r_km1, r_k;
  logic [7:0] r_abase, r_bbase;
  logic [3:0] r_slot;
  logic r_on_d, r_err;
  logic w_start, w_inc, w_last, w_mac_last, w_unused;
  logic [31:0] w_a_idx, w_b_idx;
  assign w_unused   = ^INSTRDATA[3:0];
  assign w_start    = r_state == S_IDLE && ONSWT && !r_on_d;
  assign w_last     = r_pc == PCW'(IMEM_DEPTH - 1);
  assign w_mac_last = r_k == r_km1;
  // each operand wraps inside its own region so a burst never spills into the other
  assign w_a_idx    = (32'(r_abase) + 32'(r_k)) % B_START;
  assign w_b_idx    = B_START + (32'(r_bbase) + 32'(r_k)) % (REGN - B_START);
  assign OFFSWT     = r_state == S_DONE;
  assign BUSY       = r_state != S_IDLE && r_state != S_DONE;
  assign PC_INS     = r_pc;
  assign RD_EN      = r_state == S_MAC;
  assign RD_ADDR_A  = RD_EN ? AW'(w_a_idx) : '0;
  assign RD_ADDR_B  = RD_EN ? AW'(w_b_idx) : '0;
  assign RST_MUL    = r_state == S_CLEAR ? r_mask : '0;
  assign MAC_CTRL   = r_mac;
  assign WR_VALID   = r_state == S_WRITE;
  assign WR_SLOT    = WR_VALID ? r_slot : '0;
  assign ERR        = r_err;
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    case (r_state)
      S_IDLE:   w_next = w_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: case (INSTRDATA[31:30])
        2'b00:   w_inc  = 1'b1;
        2'b01:   w_next = S_CLEAR;
        2'b10:   w_next = S_MAC;
        default: w_next = S_DONE;
      endcase
      S_CLEAR:  w_next = S_MAC;
      S_MAC:    w_next = w_mac_last ? S_DRAIN : S_MAC;
      S_DRAIN:  w_next = S_WRITE;
      S_WRITE:  w_inc  = WR_READY;
      default:  w_next = ONSWT ? S_DONE : S_IDLE;
    endcase
    if (w_inc) w_next = w_last ? S_DONE : S_FETCH;
  end
  // r_on_d resets high so a start level held through reset is not taken as a new edge
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_on_d  <= 1'b1;
      r_mask  <= '0;
      r_mac   <= '0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_km1   <= '0;
      r_abase <= '0;
      r_bbase <= '0;
      r_slot  <= '0;
    end else begin
      r_state <= w_next;
      r_on_d  <= ONSWT;
      r_mac   <= r_state == S_MAC ? r_mask : '0;
      r_k     <= (r_state == S_MAC && !w_mac_last) ? r_k + 6'd1 : '0;
      if (w_start) begin
        r_mask <= LANE_MASK;
        r_pc   <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == S_DECODE) {r_km1, r_abase, r_bbase, r_slot} <= INSTRDATA[29:4];
      if (w_inc) begin
        if (w_last) r_err <= 1'b1;
        else r_pc <= r_pc + 1'b1;
      end
    end
  end
endmodule
